// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the mem_access_ctrl SRAM access controller.
// The optional sticky error flag is built only when MEM_ACCESS_CTRL_ERR_EN is defined.
package mem_ctrl_pkg;

    localparam int SRAM_ADDR_W = 18;
    localparam int SRAM_DQ_W   = 16;
    localparam int CNT_W       = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    // An accepted access is a protocol error if both enables are high or the address is not word aligned.
    function automatic logic access_err(input logic rd, input logic wr, input logic [1:0] lsb);
        return (rd & wr) | (lsb != 2'b00);
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Pipeline-side handshake between the EXE/MEM stage (master) and the SRAM controller (slave).
interface mem_access_ctrl_if;

    logic        MEM_R_EN;
    logic        MEM_W_EN;
    logic [31:0] ALU_result;
    logic [31:0] ST_val;
    logic        freeze;
    logic        ready;
    logic [31:0] mem_rdata;

    modport master (
        output MEM_R_EN, MEM_W_EN, ALU_result, ST_val,
        input  freeze, ready, mem_rdata
    );

    modport slave (
        input  MEM_R_EN, MEM_W_EN, ALU_result, ST_val,
        output freeze, ready, mem_rdata
    );

endinterface

// File: rtl/mem_wait_cnt.sv
// Phase wait counter: clears on phase entry, counts SRAM cycles, flags the final and next-to-final cycle.
module mem_wait_cnt
    import mem_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic tc,
    output logic pre_tc
);

    localparam logic [CNT_W-1:0] TC_VAL  = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] PRE_VAL = CNT_W'(WAIT_CYCLES - 2);

    logic [CNT_W-1:0] cnt_r;

    // Cycle counter within the current half-word phase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (inc) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign tc     = (cnt_r == TC_VAL);
    assign pre_tc = (cnt_r == PRE_VAL);

endmodule

// File: rtl/mem_access_ctrl.sv
// Splits 32-bit loads/stores into two 16-bit SRAM phases (LO then HI) and freezes the pipeline meanwhile.
// Optional sticky protocol-error flag: define MEM_ACCESS_CTRL_ERR_EN.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    mem_access_ctrl_if.slave       bus,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [SRAM_DQ_W-1:0]   sram_wdata,
    output logic                   sram_dq_oe,
    input  logic [SRAM_DQ_W-1:0]   sram_rdata,
    output logic                   sram_we_n,
    output logic                   sram_oe_n,
    output logic                   err
);

    state_t                 state_r;
    logic                   op_rd_r;
    logic [16:0]            base_r;
    logic [SRAM_DQ_W-1:0]   st_hi_r;
    logic [31:0]            rdata_r;
    logic                   ready_r;
    logic                   req_s;
    logic                   phase_s;
    logic                   cnt_clr_s;
    logic                   cnt_inc_s;
    logic                   cnt_tc_s;
    logic                   cnt_pre_tc_s;
    logic                   unused_s;

    assign req_s     = bus.MEM_R_EN | bus.MEM_W_EN;
    assign phase_s   = (state_r == LO) || (state_r == HI);
    assign cnt_clr_s = !phase_s || cnt_tc_s;
    assign cnt_inc_s = phase_s && !cnt_tc_s;
    assign unused_s  = ^{bus.ALU_result[31:19], bus.ALU_result[1:0]};

    mem_wait_cnt #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_wait_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (cnt_clr_s),
        .inc    (cnt_inc_s),
        .tc     (cnt_tc_s),
        .pre_tc (cnt_pre_tc_s)
    );

    // Access FSM; SRAM strobes are registered so they are set up on phase entry and stay glitch-free.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= IDLE;
            op_rd_r    <= 1'b0;
            base_r     <= 17'd0;
            st_hi_r    <= 16'd0;
            rdata_r    <= 32'd0;
            ready_r    <= 1'b0;
            sram_addr  <= {SRAM_ADDR_W{1'b0}};
            sram_wdata <= {SRAM_DQ_W{1'b0}};
            sram_we_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_dq_oe <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    ready_r <= 1'b0;
                    if (req_s) begin
                        // A simultaneous read and write request resolves to the read.
                        state_r    <= LO;
                        op_rd_r    <= bus.MEM_R_EN;
                        base_r     <= bus.ALU_result[18:2];
                        st_hi_r    <= bus.ST_val[31:16];
                        sram_addr  <= {bus.ALU_result[18:2], 1'b0};
                        sram_wdata <= bus.MEM_R_EN ? sram_wdata : bus.ST_val[15:0];
                        sram_oe_n  <= !bus.MEM_R_EN;
                        sram_we_n  <= bus.MEM_R_EN;
                        sram_dq_oe <= !bus.MEM_R_EN;
                    end
                end
                LO: begin
                    if (cnt_tc_s) begin
                        state_r   <= HI;
                        sram_addr <= {base_r, 1'b1};
                        sram_we_n <= op_rd_r;
                        if (op_rd_r) begin
                            rdata_r[15:0] <= sram_rdata;
                        end else begin
                            sram_wdata <= st_hi_r;
                        end
                    end else begin
                        sram_we_n <= op_rd_r | cnt_pre_tc_s;
                    end
                end
                HI: begin
                    if (cnt_tc_s) begin
                        state_r    <= DONE;
                        ready_r    <= 1'b1;
                        sram_we_n  <= 1'b1;
                        sram_oe_n  <= 1'b1;
                        sram_dq_oe <= 1'b0;
                        if (op_rd_r) begin
                            rdata_r[31:16] <= sram_rdata;
                        end
                    end else begin
                        sram_we_n <= op_rd_r | cnt_pre_tc_s;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    ready_r <= 1'b0;
                end
                default: begin
                    state_r    <= IDLE;
                    ready_r    <= 1'b0;
                    sram_we_n  <= 1'b1;
                    sram_oe_n  <= 1'b1;
                    sram_dq_oe <= 1'b0;
                end
            endcase
        end
    end

    assign bus.freeze    = ((state_r == IDLE) && req_s) || phase_s;
    assign bus.ready     = ready_r;
    assign bus.mem_rdata = rdata_r;

`ifdef MEM_ACCESS_CTRL_ERR_EN
    logic err_r;

    // Sticky error, set when IDLE accepts a malformed access; only reset clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_r <= 1'b0;
        end else if ((state_r == IDLE) && req_s &&
                     access_err(bus.MEM_R_EN, bus.MEM_W_EN, bus.ALU_result[1:0])) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign err = err_r;
`else
    assign err = 1'b0;
`endif

endmodule
